// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Receives a byte stream from a host and writes it into instruction memory
//   while the core is held in reset. A session is a 4-byte little-endian word
//   count N, followed by N little-endian 32-bit words and, when the checksum
//   option is built in, one checksum byte.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     defined   : adds the CSUM state and an 8-bit running sum of DATA bytes
//     undefined : the last write goes straight to DONE
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; flags from the last session are held
//   LEN    | collecting the 4 word-count bytes
//   DATA   | collecting instruction bytes, one write per 4 bytes
//   CSUM   | collecting the checksum byte (LOADER_CHECKSUM_EN only)
//   DONE   | one cycle, sets done
//   ERROR  | one cycle, sets error
//
// Ports
//   clk_i            clock, all state on rising edge
//   rst_i            synchronous active-high reset
//   start_i          one-cycle session request (honoured in IDLE only)
//   in_data_i        host byte
//   in_valid_i       host byte valid
//   in_ready_o       block accepts a byte this cycle
//   wr_en_o          one-cycle memory write strobe
//   wr_addr_o        byte address of the word written
//   wr_data_o        word written
//   core_hold_o      keeps the core in reset during a session
//   done_o           sticky success flag
//   error_o          sticky failure flag
//   words_written_o  words written in the current session
// -----------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int              XLEN      = 32,
    parameter int              MEM_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [7:0]      in_data_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    output logic            wr_en_o,
    output logic [XLEN-1:0] wr_addr_o,
    output logic [XLEN-1:0] wr_data_o,
    output logic            core_hold_o,
    output logic            done_o,
    output logic            error_o,
    output logic [XLEN-1:0] words_written_o
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERROR} state_t;
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [31:0]       len_rem_q, len_rem_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [XLEN-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;
    logic              core_hold_q, core_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [XLEN-1:0]   words_q, words_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic        accept;
    logic [31:0] asm_word;

    assign accept   = in_valid_i && in_ready_q;
    // Bytes shift in from the top, so after three bytes the first one sits
    // in bits 7:0 and the current byte completes the little-endian word.
    assign asm_word = {in_data_i, shift_q};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_rem_d  = len_rem_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        error_d    = error_q;
        words_d    = words_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_LEN;
                    byte_cnt_d = 2'd0;
                    addr_d     = BASE_ADDR;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    words_d    = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                end
            end
            S_LEN: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {in_data_i, shift_q[23:8]};
                    if (byte_cnt_q == 2'd3) begin
                        len_rem_d = asm_word;
                        if (asm_word > MEM_WORDS_L)
                            state_d = S_ERROR;
                        else if (asm_word == 32'd0)
                            state_d = S_AFTER_DATA;
                        else
                            state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {in_data_i, shift_q[23:8]};
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = sum_q + in_data_i;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = XLEN'(asm_word);
                        addr_d    = addr_q + XLEN'(4);
                        words_d   = words_q + XLEN'(1);
                        len_rem_d = len_rem_q - 32'd1;
                        // The write strobe and the state change share a cycle,
                        // so a checksum byte may follow the last data byte
                        // immediately.
                        if (len_rem_q == 32'd1)
                            state_d = S_AFTER_DATA;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept)
                    state_d = (in_data_i == sum_q) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE)
            done_d = 1'b1;
        if (state_d == S_ERROR)
            error_d = 1'b1;

        in_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
`ifdef LOADER_CHECKSUM_EN
        if (state_d == S_CSUM)
            in_ready_d = 1'b1;
`endif
        core_hold_d = in_ready_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            shift_q     <= '0;
            len_rem_q   <= '0;
            addr_q      <= '0;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            core_hold_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            len_rem_q   <= len_rem_d;
            addr_q      <= addr_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
            words_q     <= words_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign in_ready_o      = in_ready_q;
    assign wr_en_o         = wr_en_q;
    assign wr_addr_o       = wr_addr_q;
    assign wr_data_o       = wr_data_q;
    assign core_hold_o     = core_hold_q;
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign words_written_o = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    localparam int          XLEN      = 32;
    localparam int          MEM_WORDS = 4;
    // Base close to the top of the address space so the write address wraps.
    localparam logic [31:0] BASE_ADDR = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_hold;
    logic        done;
    logic        error;
    logic [31:0] words_written;

    int n_chk  = 0;
    int n_fail = 0;

    instr_mem_loader #(
        .XLEN      (XLEN),
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .in_data_i       (in_data),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .wr_en_o         (wr_en),
        .wr_addr_o       (wr_addr),
        .wr_data_o       (wr_data),
        .core_hold_o     (core_hold),
        .done_o          (done),
        .error_o         (error),
        .words_written_o (words_written)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ww;
    } wr_t;
    wr_t wq[$];

    always @(negedge clk)
        if (wr_en) wq.push_back({wr_addr, wr_data, words_written});

    typedef struct packed {
        logic [31:0]       len;
        logic [3:0][31:0]  w;
        logic [2:0]        nw;
        logic [7:0]        gap;
        logic              mid_start;
        logic              exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called and returns at a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic pulse_start);
        int budget = 0;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_data  = b;
        in_valid = 1'b1;
        start    = pulse_start;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_session(input vec_t v);
        logic [7:0]  sum;
        logic [31:0] w;
        logic [31:0] exp_addr;
        int          budget;
        sum = 8'd0;
        wq.delete();
        pulse_start();
        chk("start_in_ready", in_ready, 1);
        chk("start_core_hold", core_hold, 1);
        chk("start_clears_done", done, 0);
        chk("start_clears_error", error, 0);
        chk("start_clears_words", words_written, 0);
        for (int b = 0; b < 4; b++) send_byte(v.len[8*b +: 8], v.gap, 1'b0);
        for (int i = 0; i < int'(v.nw); i++) begin
            w = v.w[i];
            for (int b = 0; b < 4; b++) begin
                sum = sum + w[8*b +: 8];
                send_byte(w[8*b +: 8], v.gap, v.mid_start && i == 0 && b == 2);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (!v.exp_err) send_byte(sum, v.gap, 1'b0);
`endif
        budget = 0;
        while (!(done || error) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        repeat (2) @(negedge clk);
        chk("end_done", done, !v.exp_err);
        chk("end_error", error, v.exp_err);
        chk("end_core_hold", core_hold, 0);
        chk("end_in_ready", in_ready, 0);
        chk("end_words_written", words_written, 32'(v.nw));
        chk("write_count", wq.size(), v.nw);
        for (int i = 0; i < wq.size() && i < int'(v.nw); i++) begin
            exp_addr = BASE_ADDR + 32'(4 * i);
            chk("wr_addr", wq[i].a, exp_addr);
            chk("wr_data", wq[i].d, v.w[i]);
            chk("wr_words_written", wq[i].ww, 32'(i + 1));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_core_hold"}, core_hold, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_words"}, words_written, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vecs[0] = '{len: 32'd2, w: {32'h0, 32'h0, 32'h0010_0093, 32'h0000_0013},
                    nw: 3'd2, gap: 8'd0, mid_start: 1'b0, exp_err: 1'b0};
        vecs[1] = '{len: 32'd2, w: {32'h0, 32'h0, 32'h0010_0093, 32'h0000_0013},
                    nw: 3'd2, gap: 8'd1, mid_start: 1'b1, exp_err: 1'b0};
        vecs[2] = '{len: 32'd0, w: '0, nw: 3'd0, gap: 8'd0, mid_start: 1'b0, exp_err: 1'b0};
        vecs[3] = '{len: 32'd4, w: {32'hDEAD_BEEF, 32'h8000_0001, 32'h1234_5678, 32'h0000_00FF},
                    nw: 3'd4, gap: 8'd0, mid_start: 1'b0, exp_err: 1'b0};
        vecs[4] = '{len: 32'd5, w: '0, nw: 3'd0, gap: 8'd0, mid_start: 1'b0, exp_err: 1'b1};
        vecs[5] = '{len: 32'h0100_0002, w: '0, nw: 3'd0, gap: 8'd0, mid_start: 1'b0, exp_err: 1'b1};
        vecs[6] = '{len: 32'd1, w: {32'h0, 32'h0, 32'h0, 32'h0102_0304},
                    nw: 3'd1, gap: 8'd2, mid_start: 1'b0, exp_err: 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        for (int k = 0; k < 7; k++) run_session(vecs[k]);

        // Abort mid-word, after a long stall with in_valid low.
        wq.delete();
        pulse_start();
        for (int b = 0; b < 4; b++) send_byte(b == 0 ? 8'd2 : 8'd0, 0, 1'b0);
        send_byte(8'hDD, 0, 1'b0);
        send_byte(8'hCC, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        repeat (30) @(negedge clk);
        chk("stall_in_ready", in_ready, 1);
        chk("stall_core_hold", core_hold, 1);
        chk("stall_words", words_written, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("abort");
        @(negedge clk);
        chk("abort_write_count", wq.size(), 1);
        v = '{len: 32'd1, w: {32'h0, 32'h0, 32'h0, 32'hCAFE_F00D},
              nw: 3'd1, gap: 8'd0, mid_start: 1'b0, exp_err: 1'b0};
        run_session(v);

        // Reset wins over start in the same cycle.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_prio_in_ready", in_ready, 0);
        chk("rst_prio_core_hold", core_hold, 0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum byte: the word is still written, session fails.
        wq.delete();
        pulse_start();
        for (int b = 0; b < 4; b++) send_byte(b == 0 ? 8'd1 : 8'd0, 0, 1'b0);
        send_byte(8'h04, 0, 1'b0);
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("csum_bad_error", error, 1);
        chk("csum_bad_done", done, 0);
        chk("csum_bad_writes", wq.size(), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
